// File: rtl/frame_buffer_swap_ctrl_if.sv
// rtl/frame_buffer_swap_ctrl_if.sv - signal bundle between the swap controller and its emulator, RAM and VGA neighbours
// Ports (grouped here, clock/reset stay on the module):
//   VGA timing in  : vga_hs, vga_vs, vga_x, vga_y
//   emulator side  : free_run, emu_start, emu_done, emu_adr, emu_we, emu_d
//   frame-buffer   : buf_wr_addr, buf_rd_addr, buf_we, buf_din, buf_dout
//   pixel out      : vga_r, vga_g, vga_b
//   status         : disp_page, wr_page, frame_cnt, drop_cnt, repeat_cnt
// slave modport is the controller's view, master is the surrounding system's view.
interface frame_buffer_swap_ctrl_if #(
  parameter int NUM_BUF = 2,
  parameter int X_BITS  = 8,
  parameter int Y_BITS  = 8,
  parameter int CNT_W   = 16
);
  localparam int PAGE_W = (NUM_BUF == 3) ? 2 : 1;
  localparam int A_W    = PAGE_W + X_BITS + Y_BITS;

  logic                     vga_hs;
  logic                     vga_vs;
  logic [9:0]               vga_x;
  logic [9:0]               vga_y;
  logic                     free_run;
  logic                     emu_start;
  logic                     emu_done;
  logic [X_BITS+Y_BITS-1:0] emu_adr;
  logic                     emu_we;
  logic [11:0]              emu_d;
  logic [A_W-1:0]           buf_wr_addr;
  logic [A_W-1:0]           buf_rd_addr;
  logic                     buf_we;
  logic [11:0]              buf_din;
  logic [11:0]              buf_dout;
  logic [3:0]               vga_r;
  logic [3:0]               vga_g;
  logic [3:0]               vga_b;
  logic [PAGE_W-1:0]        disp_page;
  logic [PAGE_W-1:0]        wr_page;
  logic [CNT_W-1:0]         frame_cnt;
  logic [CNT_W-1:0]         drop_cnt;
  logic [CNT_W-1:0]         repeat_cnt;

  modport slave (
    input  vga_hs, vga_vs, vga_x, vga_y, free_run, emu_done, emu_adr, emu_we, emu_d, buf_dout,
    output emu_start, buf_wr_addr, buf_rd_addr, buf_we, buf_din, vga_r, vga_g, vga_b,
    output disp_page, wr_page, frame_cnt, drop_cnt, repeat_cnt
  );

  modport master (
    output vga_hs, vga_vs, vga_x, vga_y, free_run, emu_done, emu_adr, emu_we, emu_d, buf_dout,
    input  emu_start, buf_wr_addr, buf_rd_addr, buf_we, buf_din, vga_r, vga_g, vga_b,
    input  disp_page, wr_page, frame_cnt, drop_cnt, repeat_cnt
  );
endinterface

// File: rtl/frame_buffer_swap_ctrl.sv
// rtl/frame_buffer_swap_ctrl.sv - double/triple frame-buffer swap controller with VGA read-out path
// Ports:
//   ap_clk : sole clock
//   ap_rst : asynchronous active-high reset
//   bus    : frame_buffer_swap_ctrl_if.slave (VGA timing, emulator handshake,
//            frame-buffer RAM ports, RGB out, page/statistics status)
module frame_buffer_swap_ctrl #(
  parameter int NUM_BUF     = 2,
  parameter int X_BITS      = 8,
  parameter int Y_BITS      = 8,
  parameter int SCALE_SHIFT = 1,
  parameter int CNT_W       = 16
) (
  input logic                    ap_clk,
  input logic                    ap_rst,
  frame_buffer_swap_ctrl_if.slave bus
);
  localparam int PAGE_W = (NUM_BUF == 3) ? 2 : 1;
  localparam logic [31:0] X_LIM = 32'(1) << (X_BITS + SCALE_SHIFT);
  localparam logic [31:0] Y_LIM = 32'(1) << (Y_BITS + SCALE_SHIFT);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state, state_nx;
  logic [PAGE_W-1:0] disp_page, disp_page_nx;
  logic [PAGE_W-1:0] wr_page, wr_page_nx;
  logic [PAGE_W-1:0] rdy_page, rdy_page_nx;
  logic              rdy_valid, rdy_valid_nx;
  logic [CNT_W-1:0]  frame_cnt, frame_cnt_nx;
  logic [CNT_W-1:0]  drop_cnt, drop_cnt_nx;
  logic [CNT_W-1:0]  repeat_cnt, repeat_cnt_nx;
  logic              tick_hist;
  logic              active_q;

  logic frame_level;
  logic tick;
  logic done;
  logic active;

  assign frame_level = bus.vga_hs & bus.vga_vs;
  assign tick        = frame_level & ~tick_hist;
  assign done        = (state == RUN) & bus.emu_done;
  assign active      = (32'(bus.vga_x) < X_LIM) & (32'(bus.vga_y) < Y_LIM);

  // The done update is applied first so a coinciding tick swaps in the
  // buffer that has just been completed, and the restart decision sees
  // the post-swap ready flag.
  always_comb begin
    state_nx      = state;
    disp_page_nx  = disp_page;
    wr_page_nx    = wr_page;
    rdy_page_nx   = rdy_page;
    rdy_valid_nx  = rdy_valid;
    frame_cnt_nx  = frame_cnt;
    drop_cnt_nx   = drop_cnt;
    repeat_cnt_nx = repeat_cnt;

    if (done) begin
      state_nx     = IDLE;
      rdy_page_nx  = wr_page;
      rdy_valid_nx = 1'b1;
      frame_cnt_nx = frame_cnt + CNT_W'(1);
      if (rdy_valid) begin
        drop_cnt_nx = drop_cnt + CNT_W'(1);
      end
      if (NUM_BUF == 3) begin
        // Pages are 0,1,2, so the free one is 3 minus the other two.
        wr_page_nx = PAGE_W'(2'd3 - 2'(disp_page) - 2'(wr_page));
      end
    end

    if (tick) begin
      if (rdy_valid_nx) begin
        disp_page_nx = rdy_page_nx;
        rdy_valid_nx = 1'b0;
        if (NUM_BUF == 3) begin
          rdy_page_nx = disp_page;
        end else begin
          wr_page_nx = disp_page;
        end
      end else begin
        repeat_cnt_nx = repeat_cnt + CNT_W'(1);
      end
    end

    if ((state_nx == IDLE) && (tick || bus.free_run) && ((NUM_BUF == 3) || !rdy_valid_nx)) begin
      state_nx = RUN;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state      <= IDLE;
      disp_page  <= '0;
      wr_page    <= PAGE_W'(1);
      rdy_page   <= PAGE_W'((NUM_BUF == 3) ? 2 : 0);
      rdy_valid  <= 1'b0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      repeat_cnt <= '0;
      tick_hist  <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state      <= state_nx;
      disp_page  <= disp_page_nx;
      wr_page    <= wr_page_nx;
      rdy_page   <= rdy_page_nx;
      rdy_valid  <= rdy_valid_nx;
      frame_cnt  <= frame_cnt_nx;
      drop_cnt   <= drop_cnt_nx;
      repeat_cnt <= repeat_cnt_nx;
      tick_hist  <= frame_level;
      active_q   <= active;
    end
  end

  // RAM addresses are laid out {page, x, y}; the emulator presents {y, x}.
  assign bus.emu_start   = (state == RUN);
  assign bus.buf_wr_addr = {wr_page, bus.emu_adr[X_BITS-1:0], bus.emu_adr[X_BITS+Y_BITS-1:X_BITS]};
  assign bus.buf_din     = bus.emu_d;
  assign bus.buf_we      = bus.emu_we & (state == RUN);
  assign bus.buf_rd_addr = {disp_page,
                            bus.vga_x[SCALE_SHIFT+X_BITS-1:SCALE_SHIFT],
                            bus.vga_y[SCALE_SHIFT+Y_BITS-1:SCALE_SHIFT]};

  assign bus.vga_r = active_q ? bus.buf_dout[3:0]  : 4'd0;
  assign bus.vga_g = active_q ? bus.buf_dout[7:4]  : 4'd0;
  assign bus.vga_b = active_q ? bus.buf_dout[11:8] : 4'd0;

  assign bus.disp_page  = disp_page;
  assign bus.wr_page    = wr_page;
  assign bus.frame_cnt  = frame_cnt;
  assign bus.drop_cnt   = drop_cnt;
  assign bus.repeat_cnt = repeat_cnt;
endmodule

// File: doc/frame_buffer_swap_ctrl.md
FRAME_BUFFER_SWAP_CTRL -- requirements
Module: frame_buffer_swap_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- NUM_BUF, default 2, buffer count (2 = double, 3 = triple buffering).
- X_BITS, default 8, emulated-frame X address width.
- Y_BITS, default 8, emulated-frame Y address width.
- SCALE_SHIFT, default 1, log2 of the display upscale factor.
- CNT_W, default 16, statistics counter width.
- PAGE_W is derived, 1 when NUM_BUF=2 and 2 when NUM_BUF=3.
REQ-002 The block SHALL have these ports:
- ap_clk  in  1  sole clock.
- ap_rst  in  1  reset, asynchronous and active-high.
- vga_hs, vga_vs  in  1 each  VGA controller sync levels.
- vga_x, vga_y  in  10 each  VGA pixel position.
- free_run  in  1  keeps the emulator restarting without waiting for a frame tick.
- emu_start  out  1  emulator run request.
- emu_done  in  1  one-cycle end-of-frame pulse.
- emu_adr  in  X_BITS+Y_BITS  pixel address, {y,x}.
- emu_we  in  1  pixel write strobe.
- emu_d  in  12  pixel data.
- buf_wr_addr, buf_rd_addr  out  PAGE_W+X_BITS+Y_BITS each  frame-buffer RAM ports.
- buf_we  out  1  RAM write enable.
- buf_din  out  12  RAM write data.
- buf_dout  in  12  RAM read data, available 1 cycle after the read address.
- vga_r, vga_g, vga_b  out  4 each  pixel colour.
- disp_page, wr_page  out  PAGE_W each  current display and write buffers.
- frame_cnt, drop_cnt, repeat_cnt  out  CNT_W each  frame statistics.

Function
REQ-003 The frame tick SHALL be a one-cycle pulse on the rising edge of (vga_hs & vga_vs), detected against a registered copy.
REQ-004 State machine: IDLE and RUN; emu_start SHALL equal (state==RUN).
REQ-005 IDLE->RUN SHALL occur on (frame tick | free_run) when a writable buffer exists.
- NUM_BUF=3: a writable buffer always exists.
- NUM_BUF=2: a writable buffer exists iff rdy_valid=0 after the same-cycle swap.
REQ-006 RUN->IDLE SHALL occur on emu_done, with these updates:
- rdy_page<=wr_page and rdy_valid<=1.
- frame_cnt increments.
- If rdy_valid was already 1, drop_cnt increments.
- NUM_BUF=3 only: wr_page<=3-disp_page-new rdy_page.
REQ-007 On a frame tick with rdy_valid=1, the display swap SHALL perform:
- disp_page<=rdy_page and rdy_valid<=0.
- NUM_BUF=2: wr_page<=old disp_page.
- NUM_BUF=3: rdy_page<=old disp_page.
REQ-008 On a frame tick with rdy_valid=0, repeat_cnt SHALL increment and disp_page SHALL be unchanged.
REQ-009 When emu_done and a frame tick coincide, the done update SHALL apply first and the swap SHALL use the just-completed buffer, all in one clock.
REQ-010 A frame tick during RUN SHALL NOT restart or stall the emulator.
REQ-011 disp_page SHALL change only on a frame tick, giving tear-free display.
REQ-012 For NUM_BUF=3, {disp_page, wr_page, rdy_page} SHALL always be a permutation of {0,1,2}.
REQ-013 Write-path outputs SHALL be combinational with zero latency:
- buf_wr_addr = {wr_page, emu_adr[X_BITS-1:0], emu_adr[X_BITS+Y_BITS-1:X_BITS]}.
- buf_din = emu_d.
- buf_we = emu_we & (state==RUN); writes while IDLE SHALL be discarded.
REQ-014 buf_rd_addr SHALL be the combinational value {disp_page, vga_x[SCALE_SHIFT+X_BITS-1:SCALE_SHIFT], vga_y[SCALE_SHIFT+Y_BITS-1:SCALE_SHIFT]}.
REQ-015 active SHALL be (vga_x < 2^(X_BITS+SCALE_SHIFT)) & (vga_y < 2^(Y_BITS+SCALE_SHIFT)), registered one cycle to align with buf_dout.
REQ-016 The RGB outputs SHALL be vga_r=buf_dout[3:0], vga_g=buf_dout[7:4], vga_b=buf_dout[11:8] when active_q=1, otherwise 0.
REQ-017 All counters SHALL wrap modulo 2^CNT_W.

Reset
REQ-018 While ap_rst is high, the block SHALL asynchronously set:
- state=IDLE.
- disp_page=0 and wr_page=1.
- rdy_page=2 when NUM_BUF=3, otherwise 0.
- rdy_valid=0, all counters 0 and active_q=0.
- the tick history register to 0.
REQ-019 Reset mid-RUN SHALL drop emu_start and buf_we to 0 in the same cycle, independent of ap_clk.

Verification
REQ-020 NUM_BUF=2, first tick, then emu_done 100 cycles later, then a second tick:
- First tick -> repeat_cnt=1, emu_start=1, wr_page=1.
- emu_done -> frame_cnt=1.
- Second tick -> disp_page=1, wr_page=0 and emu_start=1 in the same cycle.
REQ-021 NUM_BUF=2, free_run=1, done before the next tick -> emu_start stays 0 until the tick, after which swap and restart occur together; drop_cnt=0.
REQ-022 NUM_BUF=3, free_run=1, three done pulses between two ticks -> frame_cnt=3 and drop_cnt=2; at the tick disp_page takes the last completed page; the permutation invariant holds throughout.
REQ-023 emu_done and tick in the same cycle, NUM_BUF=2 -> the swap uses the just-finished page, rdy_valid=0, and a restart occurs on that cycle.
REQ-024 vga_x=511 then 512 with buf_dout=12'hABC -> one cycle later RGB=(C,B,A), then 0; emu_we during IDLE -> buf_we=0.
REQ-025 ap_rst pulse mid-RUN -> emu_start=0 immediately; all REQ-018 values hold.
